fc_pass_scheduler: RTL and testbench

Multi-pass sequencer for a fully-connected layer whose output neurons outnumber the physical accumulator lanes. It sits between the IFM buffer of the previous layer and a bank of NUM_PE FC accumulators. For each of OFM_DEPTH/NUM_PE passes it streams the full IFM vector and the matching weight slice into the accumulators, waits for the accumulator pipeline to drain, and commits the lane results to the OFM buffer. It uses the inter-layer start/end handshake on both sides.

---
 rtl/fc_pass_scheduler.sv | 130 +++++++++++++
 tb/tb_fc_pass_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fc_pass_scheduler.sv
// fc_pass_scheduler: sequences OFM_DEPTH/NUM_PE accumulator passes over one IFM frame
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start_from_previous        upstream IFM buffer full (level)
//   end_to_previous            IFM buffer free for refill
//   end_from_next              downstream has consumed the OFM buffer
//   start_to_next              one-cycle pulse, OFM buffer complete
//   ifm_read_en/ifm_addr       IFM buffer read port
//   wm_read_en/wm_addr         weight memory read port (pass*IFM_DEPTH + ifm_addr)
//   acc_clear/acc_en           accumulator bank control
//   ofm_write_en/ofm_addr_base OFM commit of all lanes at pass*NUM_PE
module fc_pass_scheduler #(
    parameter int IFM_DEPTH = 160,
    parameter int OFM_DEPTH = 64,
    parameter int NUM_PE    = 16,
    parameter int ACC_LAT   = 2,
    parameter int PASSES    = OFM_DEPTH / NUM_PE,
    parameter int IFM_AW    = $clog2(IFM_DEPTH),
    parameter int WM_AW     = $clog2(PASSES * IFM_DEPTH),
    parameter int OFM_AW    = ($clog2(OFM_DEPTH) > 1) ? $clog2(OFM_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_from_previous,
    output logic              end_to_previous,
    input  logic              end_from_next,
    output logic              start_to_next,
    output logic              ifm_read_en,
    output logic [IFM_AW-1:0] ifm_addr,
    output logic              wm_read_en,
    output logic [WM_AW-1:0]  wm_addr,
    output logic              acc_clear,
    output logic              acc_en,
    output logic              ofm_write_en,
    output logic [OFM_AW-1:0] ofm_addr_base
);
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int DW = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, WRITE, HOLD} state_t;

    state_t            r_state;
    logic [IFM_AW-1:0] r_ifm_addr;
    logic [PW-1:0]     r_pass;
    logic [DW-1:0]     r_drain;
    logic              r_e2p;
    logic              r_rd;
    logic              r_clr;
    logic              r_acc;
    logic              r_wr;
    logic              r_stn;

    // Outputs are registered alongside the state transition that enters the
    // state they belong to, so they line up with the state register exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ifm_addr <= '0;
            r_pass     <= '0;
            r_drain    <= '0;
            r_e2p      <= 1'b1;
            r_rd       <= 1'b0;
            r_clr      <= 1'b0;
            r_acc      <= 1'b0;
            r_wr       <= 1'b0;
            r_stn      <= 1'b0;
        end else begin
            // one cycle of memory read latency before operands reach the lanes
            r_acc <= r_rd;
            r_clr <= 1'b0;
            r_wr  <= 1'b0;
            r_stn <= 1'b0;
            case (r_state)
                IDLE: if (start_from_previous) begin
                    r_state <= CLEAR;
                    r_pass  <= '0;
                    r_e2p   <= 1'b0;
                    r_clr   <= 1'b1;
                end
                CLEAR: begin
                    r_state    <= STREAM;
                    r_ifm_addr <= '0;
                    r_rd       <= 1'b1;
                end
                STREAM: if (r_ifm_addr == IFM_AW'(IFM_DEPTH - 1)) begin
                    r_ifm_addr <= '0;
                    r_rd       <= 1'b0;
                    r_drain    <= '0;
                    if (ACC_LAT == 0) begin
                        r_state <= WRITE;
                        r_wr    <= 1'b1;
                    end else begin
                        r_state <= DRAIN;
                    end
                end else begin
                    r_ifm_addr <= r_ifm_addr + 1'b1;
                end
                DRAIN: if (int'(r_drain) == ACC_LAT - 1) begin
                    r_state <= WRITE;
                    r_wr    <= 1'b1;
                end else begin
                    r_drain <= r_drain + 1'b1;
                end
                WRITE: if (r_pass == PW'(PASSES - 1)) begin
                    r_state <= HOLD;
                    r_stn   <= 1'b1;
                    r_e2p   <= 1'b1;
                end else begin
                    r_state <= CLEAR;
                    r_pass  <= r_pass + 1'b1;
                    r_clr   <= 1'b1;
                end
                // a new upstream frame must wait: it would overwrite the OFM buffer
                HOLD: if (end_from_next) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign end_to_previous = r_e2p;
    assign start_to_next   = r_stn;
    assign ifm_read_en     = r_rd;
    assign wm_read_en      = r_rd;
    assign ifm_addr        = r_ifm_addr;
    assign wm_addr         = WM_AW'(r_pass) * WM_AW'(IFM_DEPTH) + WM_AW'(r_ifm_addr);
    assign acc_clear       = r_clr;
    assign acc_en          = r_acc;
    assign ofm_write_en    = r_wr;
    assign ofm_addr_base   = OFM_AW'(r_pass) * OFM_AW'(NUM_PE);
endmodule

// File: tb/tb_fc_pass_scheduler.sv
// tb_fc_pass_scheduler: checks the default 4-pass frame and a single-pass ACC_LAT=0 variant
module tb_fc_pass_scheduler;
    localparam int L    = 164;
    localparam int NP   = 4;
    localparam int ID   = 160;
    localparam int LAST = NP * L + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start0 = 1'b0, efn0 = 1'b0, start1 = 1'b0, efn1 = 1'b0;

    logic       e2p0, stn0, rd0, wrd0, clr0, acc0, wr0;
    logic [7:0] ifm0;
    logic [9:0] wm0;
    logic [5:0] base0;

    logic       e2p1, stn1, rd1, wrd1, clr1, acc1, wr1;
    logic [2:0] ifm1;
    logic [2:0] wm1;
    logic [1:0] base1;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fc_pass_scheduler u0 (
        .clk(clk), .reset(reset),
        .start_from_previous(start0), .end_to_previous(e2p0),
        .end_from_next(efn0), .start_to_next(stn0),
        .ifm_read_en(rd0), .ifm_addr(ifm0),
        .wm_read_en(wrd0), .wm_addr(wm0),
        .acc_clear(clr0), .acc_en(acc0),
        .ofm_write_en(wr0), .ofm_addr_base(base0)
    );

    fc_pass_scheduler #(.IFM_DEPTH(8), .OFM_DEPTH(4), .NUM_PE(4), .ACC_LAT(0)) u1 (
        .clk(clk), .reset(reset),
        .start_from_previous(start1), .end_to_previous(e2p1),
        .end_from_next(efn1), .start_to_next(stn1),
        .ifm_read_en(rd1), .ifm_addr(ifm1),
        .wm_read_en(wrd1), .wm_addr(wm1),
        .acc_clear(clr1), .acc_en(acc1),
        .ofm_write_en(wr1), .ofm_addr_base(base1)
    );

    function automatic void chk(string name, int act, int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic reset_outputs(string tag);
        chk({tag, ".end_to_previous"}, e2p0, 1);
        chk({tag, ".ifm_read_en"}, rd0, 0);
        chk({tag, ".wm_read_en"}, wrd0, 0);
        chk({tag, ".acc_clear"}, clr0, 0);
        chk({tag, ".acc_en"}, acc0, 0);
        chk({tag, ".ofm_write_en"}, wr0, 0);
        chk({tag, ".start_to_next"}, stn0, 0);
        chk({tag, ".ifm_addr"}, ifm0, 0);
        chk({tag, ".wm_addr"}, wm0, 0);
        chk({tag, ".ofm_addr_base"}, base0, 0);
    endtask

    // Runs cycles 1..LAST of a default frame whose start is sampled on the next edge.
    // Expected addresses and pulse cycles are queued up front and consumed as the DUT emits them.
    task automatic frame(input bit drop_start, input bit ack);
        int q_wm[$];
        int q_clr[$];
        int q_wr[$];
        for (int p = 0; p < NP; p++) begin
            q_clr.push_back(1 + p * L);
            q_wr.push_back(L + p * L);
            for (int i = 0; i < ID; i++) q_wm.push_back(p * ID + i);
        end
        for (int c = 1; c <= LAST; c++) begin
            int off, e;
            @(posedge clk); #1;
            off = (c - 1) % L;
            if (c == 1 && drop_start) start0 = 1'b0;
            chk("ifm_read_en", rd0, int'(c < LAST && off >= 1 && off <= ID));
            chk("wm_read_en", wrd0, int'(c < LAST && off >= 1 && off <= ID));
            chk("acc_en", acc0, int'(c < LAST && off >= 2 && off <= ID + 1));
            chk("end_to_previous", e2p0, int'(c == LAST));
            chk("start_to_next", stn0, int'(c == LAST));
            if (rd0) begin
                chk("wm_expected", int'(q_wm.size() > 0), 1);
                if (q_wm.size() > 0) begin
                    e = q_wm.pop_front();
                    chk("wm_addr", wm0, e);
                    chk("ifm_addr", ifm0, e % ID);
                end
            end
            if (clr0) begin
                chk("clr_expected", int'(q_clr.size() > 0), 1);
                if (q_clr.size() > 0) chk("acc_clear_cycle", c, q_clr.pop_front());
            end
            if (wr0) begin
                chk("wr_expected", int'(q_wr.size() > 0), 1);
                if (q_wr.size() > 0) begin
                    e = q_wr.pop_front();
                    chk("ofm_write_cycle", c, e);
                    chk("ofm_addr_base", base0, (e / L - 1) * 16);
                end
            end
        end
        chk("wm_left", q_wm.size(), 0);
        chk("clr_left", q_clr.size(), 0);
        chk("wr_left", q_wr.size(), 0);
        if (ack) efn0 = 1'b1;
    endtask

    typedef struct {
        bit s, e;
        bit clr, rd, acc, wr, stn, e2p;
        int ifm;
    } vec_t;

    vec_t tv[13];

    initial begin
        // single-pass, ACC_LAT=0 frame: inputs applied before edge k, outputs expected in cycle k+1
        tv = '{
            '{1, 0, 1, 0, 0, 0, 0, 0, 0},
            '{0, 0, 0, 1, 0, 0, 0, 0, 0},
            '{0, 0, 0, 1, 1, 0, 0, 0, 1},
            '{0, 0, 0, 1, 1, 0, 0, 0, 2},
            '{0, 0, 0, 1, 1, 0, 0, 0, 3},
            '{0, 0, 0, 1, 1, 0, 0, 0, 4},
            '{0, 0, 0, 1, 1, 0, 0, 0, 5},
            '{0, 0, 0, 1, 1, 0, 0, 0, 6},
            '{0, 0, 0, 1, 1, 0, 0, 0, 7},
            '{0, 0, 0, 0, 1, 1, 0, 0, 0},
            '{0, 0, 0, 0, 0, 0, 1, 1, 0},
            '{0, 1, 0, 0, 0, 0, 0, 1, 0},
            '{0, 0, 0, 0, 0, 0, 0, 1, 0}
        };

        #12;
        reset_outputs("por");
        @(negedge clk) reset = 1'b0;

        for (int k = 0; k < 13; k++) begin
            start1 = tv[k].s;
            efn1   = tv[k].e;
            @(posedge clk); #1;
            chk($sformatf("v%0d.acc_clear", k), clr1, tv[k].clr);
            chk($sformatf("v%0d.ifm_read_en", k), rd1, tv[k].rd);
            chk($sformatf("v%0d.wm_read_en", k), wrd1, tv[k].rd);
            chk($sformatf("v%0d.acc_en", k), acc1, tv[k].acc);
            chk($sformatf("v%0d.ofm_write_en", k), wr1, tv[k].wr);
            chk($sformatf("v%0d.start_to_next", k), stn1, tv[k].stn);
            chk($sformatf("v%0d.end_to_previous", k), e2p1, tv[k].e2p);
            chk($sformatf("v%0d.ifm_addr", k), ifm1, tv[k].ifm);
            chk($sformatf("v%0d.wm_addr", k), wm1, tv[k].ifm);
            chk($sformatf("v%0d.ofm_addr_base", k), base1, 0);
        end
        efn1 = 1'b0;

        // default frame, start dropped once end_to_previous falls
        start0 = 1'b1;
        frame(1'b1, 1'b0);

        // backpressure: stay in HOLD, ignore start toggling
        for (int i = 0; i < 50; i++) begin
            start0 = i[0];
            @(posedge clk); #1;
            chk("bp.end_to_previous", e2p0, 1);
            chk("bp.acc_clear", clr0, 0);
            chk("bp.ifm_read_en", rd0, 0);
            chk("bp.start_to_next", stn0, 0);
        end
        start0 = 1'b0;
        efn0 = 1'b1;
        @(posedge clk); #1;
        efn0 = 1'b0;
        chk("bp_release.end_to_previous", e2p0, 1);
        chk("bp_release.acc_clear", clr0, 0);

        // back-to-back: start held high, ack in the start_to_next cycle
        start0 = 1'b1;
        frame(1'b0, 1'b1);
        @(posedge clk); #1;
        efn0 = 1'b0;
        chk("b2b_idle.acc_clear", clr0, 0);
        chk("b2b_idle.end_to_previous", e2p0, 1);
        frame(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("b2b_hold.acc_clear", clr0, 0);
            chk("b2b_hold.end_to_previous", e2p0, 1);
        end
        start0 = 1'b0;
        efn0 = 1'b1;
        @(posedge clk); #1;
        efn0 = 1'b0;

        // mid-frame reset during pass 2 at ifm_addr 50
        start0 = 1'b1;
        for (int c = 1; c <= 380; c++) begin
            @(posedge clk); #1;
            if (c == 1) start0 = 1'b0;
        end
        chk("pre_reset.ifm_addr", ifm0, 50);
        chk("pre_reset.wm_addr", wm0, 370);
        chk("pre_reset.ofm_addr_base", base0, 32);
        chk("pre_reset.acc_en", acc0, 1);
        #3 reset = 1'b1;
        #1 reset_outputs("async_reset");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("in_reset.ofm_write_en", wr0, 0);
            chk("in_reset.start_to_next", stn0, 0);
            chk("in_reset.end_to_previous", e2p0, 1);
        end
        @(negedge clk);
        reset = 1'b0;
        start0 = 1'b1;
        frame(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
